sc_io_port_ctrl: RTL

- Parametrised memory-mapped I/O controller for the single-cycle computer.
- Replaces the fixed switch/key/hex/LED wiring with debounced, synchronised inputs, sticky key-press event flags (clear-on-read), and a writable LED register.
- Also provides per-digit hex registers with built-in 7-segment decode and blanking.
- Sits between the CPU data-memory I/O decode and the board pins.

---
 rtl/sc_io_port_ctrl_pkg.sv | 47 ++++
 rtl/sc_io_port_ctrl_if.sv | 24 ++
 rtl/sc_io_port_ctrl_debounce.sv | 70 +++++++
 rtl/sc_io_port_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sc_io_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_io_pkg
//  Description : Shared definitions for the single-cycle computer I/O port
//                controller: register word offsets inside the I/O window,
//                the blanked-digit segment pattern and the active-low
//                7-segment decode table.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_io_pkg;

    // Word offsets inside the I/O window
    localparam logic [3:0] OFF_SW     = 4'h0;
    localparam logic [3:0] OFF_KEYLVL = 4'h1;
    localparam logic [3:0] OFF_KEYEVT = 4'h2;
    localparam logic [3:0] OFF_LED    = 4'h3;
    localparam logic [3:0] OFF_HEX0   = 4'h4;

    // All segments off (segments are active-low)
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low hexadecimal glyph table, bit 0 = segment a
    function automatic logic [6:0] seg7_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_io_port_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sc_io_port_ctrl_if
//  Description : CPU-side memory-mapped access bus of the I/O controller.
//                Ports:
//                  addr  [3:0]  word offset inside the I/O window
//                  wdata [31:0] write data
//                  we           write strobe, sampled on the clock edge
//                  re           read strobe (side effects on the clock edge)
//                  rdata [31:0] read data, combinational from addr
//                master = CPU decode side, slave = the I/O controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sc_io_port_ctrl_if;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, output re, input  rdata);
    modport slave  (input  addr, input  wdata, input  we, input  re, output rdata);
endinterface
`default_nettype wire

// File: rtl/sc_io_port_ctrl_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sc_io_debounce
//  Description : Per-bit two-flop synchroniser followed by a stability
//                counter. A bit's debounced level flips only after the
//                synchronised level has disagreed with it for
//                DEBOUNCE_CYCLES consecutive clocks.
//                Ports:
//                  clock, resetn   clock / asynchronous active-low reset
//                  din   [W-1:0]   raw asynchronous inputs, active-high
//                  dout  [W-1:0]   debounced level
//                  rise  [W-1:0]   high in the cycle whose edge raises dout
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_io_debounce #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic             clock,
    input  wire logic             resetn,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic      [WIDTH-1:0] rise
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [CW-1:0] r_cnt;
        logic          r_deb;
        logic          w_flip;

        // The counter has already seen DEBOUNCE_CYCLES-1 disagreeing clocks;
        // this edge is the DEBOUNCE_CYCLES-th, so the new level is accepted.
        assign w_flip = (r_sync2[b] != r_deb) && (r_cnt == CNT_MAX);

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_cnt <= '0;
                r_deb <= 1'b0;
            end else if (r_sync2[b] == r_deb) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt <= '0;
                r_deb <= ~r_deb;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end

        assign dout[b] = r_deb;
        assign rise[b] = w_flip & ~r_deb;
    end

endmodule
`default_nettype wire

// File: rtl/sc_io_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sc_io_port_ctrl
//  Description : Memory-mapped I/O controller for the single-cycle computer.
//                Debounced switches and keys, sticky key-press flags
//                (clear-on-read and write-1-to-clear), a writable LED
//                register and per-digit hex registers with 7-segment decode.
//                Ports:
//                  clock, resetn      clock / asynchronous active-low reset
//                  bus (slave)        CPU register access
//                  sw   [N_SW-1:0]    raw switches, active-high
//                  key  [N_KEY-1:0]   raw keys, active-low
//                  hex  [7*N_HEX-1:0] segments, active-low, digit i at [7i+:7]
//                  led  [N_LED-1:0]   LED register
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_io_port_ctrl
    import sc_io_pkg::*;
#(
    parameter int N_SW            = 10,
    parameter int N_KEY           = 4,
    parameter int N_HEX           = 6,
    parameter int N_LED           = 10,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  wire logic               clock,
    input  wire logic               resetn,
    sc_io_port_ctrl_if.slave        bus,
    input  wire logic [N_SW-1:0]    sw,
    input  wire logic [N_KEY-1:0]   key,
    output logic      [7*N_HEX-1:0] hex,
    output logic      [N_LED-1:0]   led
);

    logic [N_SW-1:0]  w_sw_deb;
    logic [N_SW-1:0]  w_sw_rise;
    logic [N_KEY-1:0] w_key_deb;
    logic [N_KEY-1:0] w_key_rise;
    logic [N_KEY-1:0] w_evt_clr;
    logic [N_KEY-1:0] r_keyevt;
    logic [N_LED-1:0] r_led;
    logic [3:0]       w_hex_val   [N_HEX];
    logic             w_hex_blank [N_HEX];
    logic [31:0]      w_rdata;
    logic             w_evt_sel;
    logic             w_unused;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    sc_io_debounce #(
        .WIDTH           (N_SW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clock  (clock),
        .resetn (resetn),
        .din    (sw),
        .dout   (w_sw_deb),
        .rise   (w_sw_rise)
    );

    // Keys are inverted first so that the synchroniser reset level (0)
    // corresponds to "released".
    sc_io_debounce #(
        .WIDTH           (N_KEY),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clock  (clock),
        .resetn (resetn),
        .din    (~key),
        .dout   (w_key_deb),
        .rise   (w_key_rise)
    );

    // ------------------------------------------------------------------
    // Key event flags: a read strobe clears all flags, a write clears the
    // flags selected by wdata; a press landing on the same edge wins.
    // ------------------------------------------------------------------
    assign w_evt_sel = (bus.addr == OFF_KEYEVT);
    assign w_evt_clr = ({N_KEY{bus.re & w_evt_sel}})
                     | ((bus.we & w_evt_sel) ? bus.wdata[N_KEY-1:0] : '0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_keyevt <= '0;
        end else begin
            r_keyevt <= (r_keyevt & ~w_evt_clr) | w_key_rise;
        end
    end

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_led <= '0;
        end else if (bus.we && (bus.addr == OFF_LED)) begin
            r_led <= bus.wdata[N_LED-1:0];
        end
    end

    assign led = r_led;

    // ------------------------------------------------------------------
    // Hex digit registers and segment decode
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_HEX; i++) begin : g_hex
        localparam logic [3:0] C_OFF = OFF_HEX0 + 4'(i);

        logic [3:0] r_val;
        logic       r_blank;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_val   <= 4'h0;
                r_blank <= 1'b1;
            end else if (bus.we && (bus.addr == C_OFF)) begin
                r_val   <= bus.wdata[3:0];
                r_blank <= bus.wdata[4];
            end
        end

        assign w_hex_val[i]   = r_val;
        assign w_hex_blank[i] = r_blank;
        assign hex[7*i +: 7]  = r_blank ? SEG_OFF : seg7_decode(r_val);
    end

    // ------------------------------------------------------------------
    // Read mux (combinational; KEYEVT reads return the pre-clear value)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (bus.addr)
            OFF_SW:     w_rdata = 32'(w_sw_deb);
            OFF_KEYLVL: w_rdata = 32'(w_key_deb);
            OFF_KEYEVT: w_rdata = 32'(r_keyevt);
            OFF_LED:    w_rdata = 32'(r_led);
            default: begin
                for (int i = 0; i < N_HEX; i++) begin
                    if (bus.addr == (OFF_HEX0 + 4'(i))) begin
                        w_rdata = {27'b0, w_hex_blank[i], w_hex_val[i]};
                    end
                end
            end
        endcase
    end

    assign bus.rdata = w_rdata;

    // Switch press edges and the upper write-data bits have no consumer.
    assign w_unused = &{1'b0, w_sw_rise, bus.wdata};

endmodule
`default_nettype wire
